// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-organised data store for the MEM stage.
// Answers loads/stores after LATENCY cycles and stalls the pipeline meanwhile.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memStall,
  output logic        addrErr,
  output logic        bothErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        req;
  logic        fire;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  logic        unused_addr;

  assign req  = memRead | memWrite;
  assign idx  = addr[AW+1:2];
  assign fire = (state_nxt == DONE);
  assign unused_addr = ^addr[31:AW+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Dropping the request while BUSY is a pipeline flush: abandon quietly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    memStall = req && (state != DONE);
  end

  // Writes win when both enables are high; error flags live for DONE only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readData <= '0;
      addrErr  <= 1'b0;
      bothErr  <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      addrErr <= 1'b0;
      bothErr <= 1'b0;
      if (fire) begin
        if (memWrite) begin
          mem[idx] <= writeData;
        end else begin
          readData <= mem[idx];
        end
        addrErr <= |addr[1:0];
        bothErr <= memRead & memWrite;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks of dmem_responder
// at LATENCY 2, 4 and 1 against a word-array reference model.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] ad    [3];
  logic [31:0] wd    [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        aerr  [3];
  logic        berr  [3];

  logic [31:0] mem_m   [3][256];
  logic [31:0] rdata_m [3];

  int checks;
  int errors;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst),
    .memRead(rd[0]), .memWrite(wr[0]),
    .addr(ad[0]), .writeData(wd[0]),
    .readData(rdata[0]), .memStall(stall[0]),
    .addrErr(aerr[0]), .bothErr(berr[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u1 (
    .clk(clk), .rst(rst),
    .memRead(rd[1]), .memWrite(wr[1]),
    .addr(ad[1]), .writeData(wd[1]),
    .readData(rdata[1]), .memStall(stall[1]),
    .addrErr(aerr[1]), .bothErr(berr[1])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u2 (
    .clk(clk), .rst(rst),
    .memRead(rd[2]), .memWrite(wr[2]),
    .addr(ad[2]), .writeData(wd[2]),
    .readData(rdata[2]), .memStall(stall[2]),
    .addrErr(aerr[2]), .bothErr(berr[2])
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    if (k == 0) return 2;
    if (k == 1) return 4;
    return 1;
  endfunction

  task automatic chk(input string tag, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d]: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rdata_m[k] = '0;
      for (int i = 0; i < 256; i++) mem_m[k][i] = '0;
    end
  endtask

  // Called just after a rising edge; leaves the request asserted after DONE.
  task automatic access(input int k, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a >> 2) % 256;
    rd[k] = r;
    wr[k] = w;
    ad[k] = a;
    wd[k] = d;
    for (int i = 0; i < lat_of(k); i++) begin
      @(negedge clk);
      chk("stall_wait", k, 32'(stall[k]), 32'd1);
      chk("aerr_wait", k, 32'(aerr[k]), 32'd0);
      chk("berr_wait", k, 32'(berr[k]), 32'd0);
      @(posedge clk);
      #1;
    end
    if (w) mem_m[k][idx] = d;
    else if (r) rdata_m[k] = mem_m[k][idx];
    @(negedge clk);
    chk("stall_done", k, 32'(stall[k]), 32'd0);
    chk("rdata_done", k, rdata[k], rdata_m[k]);
    chk("aerr_done", k, 32'(aerr[k]), 32'((a % 4) != 0));
    chk("berr_done", k, 32'(berr[k]), 32'(r && w));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    @(negedge clk);
    chk("stall_idle", k, 32'(stall[k]), 32'd0);
    chk("aerr_idle", k, 32'(aerr[k]), 32'd0);
    chk("berr_idle", k, 32'(berr[k]), 32'd0);
    chk("rdata_idle", k, rdata[k], rdata_m[k]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int op;
    clk = 1'b0;
    rst = 1'b0;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      ad[k] = '0;
      wd[k] = '0;
    end
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", k, rdata[k], 32'd0);
      chk("rst_stall", k, 32'(stall[k]), 32'd0);
      chk("rst_aerr", k, 32'(aerr[k]), 32'd0);
      chk("rst_berr", k, 32'(berr[k]), 32'd0);
    end
    rd[2] = 1'b1;
    #1;
    chk("rst_stall_req", 2, 32'(stall[2]), 32'd1);
    rd[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Store then load, LATENCY 2
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    idle(0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    idle(0);
    // Index wrap-around
    access(0, 1'b0, 1'b1, 32'h004, 32'h12345678);
    idle(0);
    access(0, 1'b1, 1'b0, 32'h404, 32'h0);
    idle(0);
    // Misaligned load hits word 4
    access(0, 1'b1, 1'b0, 32'h13, 32'h0);
    idle(0);
    // Both enables: treated as a write
    access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    idle(0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0);
    idle(0);

    // Abort after one BUSY cycle, LATENCY 4
    access(1, 1'b0, 1'b1, 32'h40, 32'h11111111);
    idle(1);
    wr[1] = 1'b1;
    ad[1] = 32'h40;
    wd[1] = 32'h22222222;
    @(negedge clk);
    chk("abort_stall0", 1, 32'(stall[1]), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_stall1", 1, 32'(stall[1]), 32'd1);
    @(posedge clk);
    #1;
    idle(1);
    idle(1);
    access(1, 1'b1, 1'b0, 32'h40, 32'h0);
    idle(1);

    // Reset during a BUSY store
    wr[0] = 1'b1;
    ad[0] = 32'h30;
    wd[0] = 32'h55AA55AA;
    @(negedge clk);
    chk("prerst_stall", 0, 32'(stall[0]), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_rdata", 0, rdata[0], 32'd0);
    chk("midrst_stall", 0, 32'(stall[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("postrst_stall", 0, 32'(stall[0]), 32'd1);
    wr[0] = 1'b0;
    @(posedge clk);
    #1;
    idle(0);
    access(0, 1'b1, 1'b0, 32'h30, 32'h0);
    idle(0);

    // LATENCY 1, back-to-back loads
    access(2, 1'b0, 1'b1, 32'h8, 32'hCAFE0001);
    idle(2);
    access(2, 1'b0, 1'b1, 32'hC, 32'hCAFE0002);
    idle(2);
    access(2, 1'b1, 1'b0, 32'h8, 32'h0);
    access(2, 1'b1, 1'b0, 32'hC, 32'h0);
    idle(2);

    // Random traffic on every latency
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        op = int'($urandom_range(0, 3));
        a = $urandom;
        a[9:2] = 8'($urandom_range(0, 7));
        access(k, (op != 1), (op == 1 || op == 2), a, $urandom);
        if ($urandom_range(0, 2) != 0) idle(k);
      end
      idle(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
